video_capture: RTL and testbench

- Receive end of the FSX pixel interface: takes an RGB332 pixel stream with hsync, vsync and blank, and writes one frame into a framebuffer RAM.
- Used for frame grab and loopback self-test. Runs on the pixel clock domain, fed by TimingGenerator-style timing or by FSX output taps.
- Optional 2x decimation mirrors the FSX scale2x path, so a 640x480 stream lands in a 320x240 buffer.

---
 rtl/gpu_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 39 +++
 rtl/video_capture.sv | 174 +++++++++++++++++
 tb/tb_video_capture.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the FSX pixel path: RGB332 field widths, sync polarity
// and the capture FSM encoding.
package gpu_pkg;

  localparam int unsigned R_W   = 3;
  localparam int unsigned G_W   = 3;
  localparam int unsigned B_W   = 2;
  localparam int unsigned PIX_W = R_W + G_W + B_W;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitVs  = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers vsync and blank once and flags the vsync falling edge and the
// blank rising edge (end of an active line) from that registered copy.
module sync_edge_detect
  import gpu_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vs,
  input  logic i_blank,
  output logic o_blank,
  output logic o_vs_fall,
  output logic o_blank_rise
);

  logic r_vs;
  logic r_vs_prev;
  logic r_blank;
  logic r_blank_prev;

  // Reset values chosen so that no edge can be reported right after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vs         <= SYNC_ACTIVE;
      r_vs_prev    <= SYNC_ACTIVE;
      r_blank      <= 1'b1;
      r_blank_prev <= 1'b1;
    end else begin
      r_vs         <= i_vs;
      r_vs_prev    <= r_vs;
      r_blank      <= i_blank;
      r_blank_prev <= r_blank;
    end
  end

  assign o_blank      = r_blank;
  assign o_vs_fall    = (r_vs_prev != SYNC_ACTIVE) && (r_vs == SYNC_ACTIVE);
  assign o_blank_rise = r_blank && !r_blank_prev;

endmodule

// File: rtl/video_capture.sv
// Frame grabber: captures one RGB332 frame (optionally decimated 2x) from the
// pixel stream into a framebuffer, one write per clock, two clocks after the pins.
module video_capture
  import gpu_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SCALE    = 2,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_blank,
  input  logic [R_W-1:0]    i_r,
  input  logic [G_W-1:0]    i_g,
  input  logic [B_W-1:0]    i_b,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_short_frame,
  output logic              o_overflow
);

  localparam int unsigned V_OUT = V_ACTIVE / SCALE;
  localparam int unsigned X_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned L_W   = $clog2(V_OUT + 1);
  localparam logic [X_W-1:0] X_END = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_END = Y_W'(V_ACTIVE);
  localparam logic [L_W-1:0] L_END = L_W'(V_OUT);

  cap_state_e        r_state, w_state_next;
  logic [X_W-1:0]    r_x, w_x_next;
  logic [Y_W-1:0]    r_y, w_y_next;
  logic [L_W-1:0]    r_line_wr, w_line_wr_next, w_line_inc;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
  logic [PIX_W-1:0]  r_wr_data, w_wr_data_next;
  logic              r_wr_en, w_wr_en_next;
  logic              r_short, w_short_next;
  logic              r_ovf, w_ovf_next;
  logic [PIX_W-1:0]  r_pix;
  logic              r_hs;
  logic              w_unused_hs;
  logic              w_blank, w_vs_fall, w_blank_rise;
  logic              w_keep, w_in_range, w_line_kept, w_complete;

  sync_edge_detect u_sync_edge_detect (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_vs        (i_vs),
    .i_blank     (i_blank),
    .o_blank     (w_blank),
    .o_vs_fall   (w_vs_fall),
    .o_blank_rise(w_blank_rise)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pix <= '0;
      r_hs  <= ~SYNC_ACTIVE;
    end else begin
      r_pix <= {i_r, i_g, i_b};
      r_hs  <= i_hs;
    end
  end

  // hsync is carried through the input stage for timing parity only.
  assign w_unused_hs = r_hs;

  assign w_keep      = (SCALE == 1) || (!r_x[0] && !r_y[0]);
  assign w_in_range  = (r_x < X_END) && (r_y < Y_END);
  assign w_line_kept = ((SCALE == 1) || !r_y[0]) && (r_y < Y_END);
  assign w_line_inc  = r_line_wr + 1'b1;
  assign w_complete  = w_blank_rise && w_line_kept && (w_line_inc == L_END);

  always_comb begin
    w_state_next   = r_state;
    w_x_next       = r_x;
    w_y_next       = r_y;
    w_line_wr_next = r_line_wr;
    w_wr_ptr_next  = r_wr_ptr;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_wr_en_next   = 1'b0;
    w_short_next   = r_short;
    w_ovf_next     = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (i_arm) begin
          w_state_next = StWaitVs;
          w_short_next = 1'b0;
          w_ovf_next   = 1'b0;
        end
      end
      StWaitVs: begin
        if (w_vs_fall) begin
          w_state_next   = StCapture;
          w_x_next       = '0;
          w_y_next       = '0;
          w_line_wr_next = '0;
          w_wr_ptr_next  = '0;
        end
      end
      StCapture: begin
        if (!w_blank) begin
          if (w_keep && w_in_range) begin
            w_wr_en_next   = 1'b1;
            w_wr_data_next = r_pix;
            w_wr_addr_next = r_wr_ptr;
            w_wr_ptr_next  = r_wr_ptr + 1'b1;
          end
          if (r_x == X_END) w_ovf_next = 1'b1;
          else              w_x_next   = r_x + 1'b1;
        end
        if (w_blank_rise) begin
          w_x_next = '0;
          if (r_y >= Y_END) w_ovf_next = 1'b1;
          else              w_y_next   = r_y + 1'b1;
          if (w_line_kept) w_line_wr_next = w_line_inc;
        end
        // A full frame beats a simultaneous vsync: no short_frame then.
        if (w_complete) begin
          w_state_next = StDone;
        end else if (w_vs_fall) begin
          w_state_next = StDone;
          w_short_next = 1'b1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_x       <= '0;
      r_y       <= '0;
      r_line_wr <= '0;
      r_wr_ptr  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_short   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_x       <= w_x_next;
      r_y       <= w_y_next;
      r_line_wr <= w_line_wr_next;
      r_wr_ptr  <= w_wr_ptr_next;
      r_wr_addr <= w_wr_addr_next;
      r_wr_data <= w_wr_data_next;
      r_wr_en   <= w_wr_en_next;
      r_short   <= w_short_next;
      r_ovf     <= w_ovf_next;
    end
  end

  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_wr_en       = r_wr_en;
  assign o_busy        = (r_state == StWaitVs) || (r_state == StCapture);
  assign o_done        = (r_state == StDone);
  assign o_short_frame = r_short;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench: a SCALE=2 and a SCALE=1 capture unit share one small video
// stream; expected writes come from frame coordinates, checked by a monitor.
module tb_video_capture;

  localparam int H      = 16;
  localparam int V      = 12;
  localparam int AW     = 8;
  localparam int HBLANK = 6;

  typedef struct {
    int     addr;
    int     data;
    longint t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b1;
  logic [2:0] r = '0, g = '0;
  logic [1:0] b = '0;

  logic [AW-1:0] waddr [2];
  logic [7:0]    wdata [2];
  logic          wen [2], busy [2], done [2], shortf [2], ovf [2];

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE(2), .ADDR_W(AW)) u_dut_s2 (
    .i_clk(clk), .i_reset(rst), .i_arm(arm), .i_hs(hs), .i_vs(vs), .i_blank(blank),
    .i_r(r), .i_g(g), .i_b(b), .o_wr_addr(waddr[0]), .o_wr_data(wdata[0]),
    .o_wr_en(wen[0]), .o_busy(busy[0]), .o_done(done[0]), .o_short_frame(shortf[0]),
    .o_overflow(ovf[0])
  );

  video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE(1), .ADDR_W(AW)) u_dut_s1 (
    .i_clk(clk), .i_reset(rst), .i_arm(arm), .i_hs(hs), .i_vs(vs), .i_blank(blank),
    .i_r(r), .i_g(g), .i_b(b), .o_wr_addr(waddr[1]), .o_wr_data(wdata[1]),
    .o_wr_en(wen[1]), .o_busy(busy[1]), .o_done(done[1]), .o_short_frame(shortf[1]),
    .o_overflow(ovf[1])
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  bit   m_cap [2], m_armed [2], exp_short [2], exp_ovf [2];
  int   exp_done [2], done_cnt [2], wr_cnt [2], last_addr [2];
  int   mem0 [256];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int scale_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic hs_at(input int c, input int len);
    return !(c >= len + 2 && c < len + 4);
  endfunction

  // Reference model: frame coordinates to buffer address, per capture unit.
  task automatic model_pixel(input int x, input int y, input int pix);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      int s = scale_of(d);
      if (m_cap[d]) begin
        if (x >= H) exp_ovf[d] = 1'b1;
        else if (y < V && x % s == 0 && y % s == 0) begin
          e.addr = (y / s) * (H / s) + x / s;
          e.data = pix;
          e.t    = cyc + 2;
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  endtask

  task automatic model_line_end(input int y);
    for (int d = 0; d < 2; d++) begin
      int s = scale_of(d);
      if (m_cap[d] && y % s == 0 && y < V && y / s + 1 == V / s) begin
        m_cap[d] = 1'b0;
        exp_done[d]++;
      end
    end
  endtask

  task automatic model_vs_fall();
    for (int d = 0; d < 2; d++) begin
      if (m_cap[d]) begin
        m_cap[d]     = 1'b0;
        exp_short[d] = 1'b1;
        exp_done[d]++;
      end else if (m_armed[d]) begin
        m_armed[d] = 1'b0;
        m_cap[d]   = 1'b1;
      end
    end
  endtask

  task automatic model_arm();
    for (int d = 0; d < 2; d++) begin
      if (!m_cap[d] && !m_armed[d]) begin
        m_armed[d]   = 1'b1;
        exp_short[d] = 1'b0;
        exp_ovf[d]   = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_cap[d]     = 1'b0;
      m_armed[d]   = 1'b0;
      exp_short[d] = 1'b0;
      exp_ovf[d]   = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic bl, input logic [7:0] pix,
                       input logic a, input logic rs);
    @(posedge clk);
    #1;
    vs = v; hs = h; blank = bl; {r, g, b} = pix; arm = a; rst = rs;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d wr_en", tag, d), longint'(wen[d]), 0);
      check($sformatf("%s dut%0d busy", tag, d), longint'(busy[d]), 0);
      check($sformatf("%s dut%0d done", tag, d), longint'(done[d]), 0);
      check($sformatf("%s dut%0d short_frame", tag, d), longint'(shortf[d]), 0);
      check($sformatf("%s dut%0d overflow", tag, d), longint'(ovf[d]), 0);
    end
  endtask

  task automatic run_frame(input int n_lines, input int long_y, input int arm_y,
                           input int arm_x, input bit pattern, input int rst_y,
                           input int rst_x);
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < H + HBLANK; c++) begin
        drive(logic'(l >= 2), hs_at(c, H), 1'b1, 8'd0, 1'b0, 1'b0);
        if (l == 0 && c == 0) model_vs_fall();
      end
    end
    for (int y = 0; y < n_lines; y++) begin
      int len = (y == long_y) ? H + 10 : H;
      for (int c = 0; c < len + HBLANK; c++) begin
        int   pix    = pattern ? (c + y) % 256 : int'($urandom_range(255, 0));
        logic active = logic'(c < len);
        logic a      = logic'(y == arm_y && c == arm_x);
        logic rs     = logic'(y == rst_y && c >= rst_x && c < rst_x + 3);
        drive(1'b1, hs_at(c, len), !active, 8'(pix), a, rs);
        if (y == rst_y && c == rst_x) begin
          model_reset();
          #1;
          check_idle_outputs("reset mid-capture");
        end
        if (active) model_pixel(c, y, pix);
        if (c == len) model_line_end(y);
        if (a) model_arm();
      end
    end
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < H + HBLANK; c++) drive(1'b1, hs_at(c, H), 1'b1, 8'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic arm_pulse();
    drive(1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
    model_arm();
    drive(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_end(input string tag);
    repeat (30) drive(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    check({tag, " dut0 pending writes"}, q0.size(), 0);
    check({tag, " dut1 pending writes"}, q1.size(), 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d done pulses", tag, d), done_cnt[d], exp_done[d]);
      check($sformatf("%s dut%0d short_frame", tag, d), longint'(shortf[d]), exp_short[d]);
      check($sformatf("%s dut%0d overflow", tag, d), longint'(ovf[d]), exp_ovf[d]);
      check($sformatf("%s dut%0d busy", tag, d), longint'(busy[d]), 0);
    end
  endtask

  task automatic check_writes(input string tag, input int b0, input int b1, input int e0,
                              input int e1);
    check({tag, " dut0 write count"}, wr_cnt[0] - b0, e0);
    check({tag, " dut1 write count"}, wr_cnt[1] - b1, e1);
  endtask

  task automatic mon_write(input int d, input int a, input int dat);
    exp_t e;
    bit   ok = 1'b0;
    if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d unexpected write: addr %0d data %0d, expected no write", d, a, dat);
    end else begin
      check($sformatf("dut%0d wr_addr", d), a, e.addr);
      check($sformatf("dut%0d wr_data", d), dat, e.data);
      check($sformatf("dut%0d write cycle", d), cyc, e.t);
    end
    wr_cnt[d]++;
    last_addr[d] = a;
    if (d == 0) mem0[a] = dat;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (wen[d]) mon_write(d, int'(waddr[d]), int'(wdata[d]));
        if (done[d]) done_cnt[d]++;
      end
    end
  endtask

  task automatic stim();
    int b0, b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d wr_addr", d), longint'(waddr[d]), 0);
      check($sformatf("reset dut%0d wr_data", d), longint'(wdata[d]), 0);
    end
    repeat (4) drive(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

    // Full frame, (x+y) pattern.
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    arm_pulse();
    run_frame(V, -1, -1, -1, 1'b1, -1, -1);
    check_end("full pattern");
    check_writes("full pattern", b0, b1, (H / 2) * (V / 2), H * V);
    check("word at x=2 y=2", mem0[H / 2 + 1], 4);
    check("dut0 last addr", last_addr[0], (H / 2) * (V / 2) - 1);
    check("dut1 last addr", last_addr[1], H * V - 1);

    // Full frame, random pixels.
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    arm_pulse();
    run_frame(V, -1, -1, -1, 1'b0, -1, -1);
    check_end("full random");
    check_writes("full random", b0, b1, (H / 2) * (V / 2), H * V);

    // Arm mid-frame, then re-arm during capture.
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    run_frame(V, -1, 4, 3, 1'b0, -1, -1);
    run_frame(V, -1, 3, 5, 1'b0, -1, -1);
    check_end("mid-frame arm");
    check_writes("mid-frame arm", b0, b1, (H / 2) * (V / 2), H * V);

    // Vsync after 6 active lines.
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    arm_pulse();
    run_frame(6, -1, -1, -1, 1'b0, -1, -1);
    run_frame(V, -1, -1, -1, 1'b0, -1, -1);
    check_end("short frame");
    check_writes("short frame", b0, b1, 3 * (H / 2), 6 * H);

    // One over-long kept line.
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    arm_pulse();
    run_frame(V, 2, -1, -1, 1'b0, -1, -1);
    check_end("long line");
    check_writes("long line", b0, b1, (H / 2) * (V / 2), H * V);

    // Reset mid-capture, then a fresh capture.
    arm_pulse();
    run_frame(V, -1, -1, -1, 1'b0, 2, 5);
    check_end("after reset");
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    arm_pulse();
    run_frame(V, -1, -1, -1, 1'b0, -1, -1);
    check_end("post-reset frame");
    check_writes("post-reset frame", b0, b1, (H / 2) * (V / 2), H * V);
  endtask

  initial begin
    fork
      monitor();
      stim();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
